// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst drain controller: default widths and
// the drain FSM state encoding.
package fifo_burst_reader_pkg;

   localparam int DEF_ADDR_W    = 11;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_BURST_LEN = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DRAIN = 2'd2
   } burst_state_t;

endpackage

// File: rtl/fifo_burst_reader_addr_sync_filter.sv
// Brings the foreign-domain FIFO write address into the read clock domain:
// a two-flop synchronizer followed by an agreement filter against multi-bit skew.
module addr_sync_filter
   import fifo_burst_reader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] addr_sync
);

   logic [ADDR_W-1:0] sync_a;
   logic [ADDR_W-1:0] sync_b;

   // A value is accepted only once two consecutive synchronizer samples agree,
   // so a sample caught mid-transition never reaches addr_sync.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a    <= '0;
         sync_b    <= '0;
         addr_sync <= '0;
      end else begin
         sync_a <= addr;
         sync_b <= sync_a;
         if (sync_a == sync_b) begin
            addr_sync <= sync_b;
         end
      end
   end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side drain controller: waits for a full burst in the tracking FIFO, then
// pulls BURST_LEN bytes through a 2-entry buffer onto a valid/ready byte stream.
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] fifo_addr_in,
   input  logic [ADDR_W-1:0] fifo_addr_out,
   output logic              fifo_read,
   input  logic [DATA_W-1:0] fifo_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic [ADDR_W-1:0] level,
   output logic              busy,
   output burst_state_t      state_dbg
);

   // Stream handshake: a byte transfers on every rising clk edge where
   // m_valid & m_ready; while m_valid is high and m_ready low, m_data and
   // m_last hold their values.

   localparam logic [ADDR_W-1:0] BURST_CNT = ADDR_W'(BURST_LEN);

   burst_state_t      state;
   logic [ADDR_W-1:0] wr_sync;
   logic [ADDR_W-1:0] level_q;
   logic [ADDR_W-1:0] remaining;
   logic              busy_q;
   logic              rd_d1;
   logic              last_d1;

   logic [DATA_W-1:0] data0;
   logic [DATA_W-1:0] data1;
   logic              last0;
   logic              last1;
   logic [1:0]        cnt;

   logic              push;
   logic              pop;
   logic              can_issue;

   addr_sync_filter #(
      .ADDR_W (ADDR_W)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .addr      (fifo_addr_in),
      .addr_sync (wr_sync)
   );

   assign m_valid = (cnt != 2'd0);
   assign pop     = m_valid & m_ready;
   assign push    = rd_d1;

   // Occupancy counts bytes held plus the one in flight plus this new read,
   // credited with the pop happening this cycle; this keeps 1 byte/cycle.
   assign can_issue = ({1'b0, cnt} + {2'b00, rd_d1} + 3'd1) <= ({2'b00, pop} + 3'd2);
   assign fifo_read = (state == ST_BURST) && (remaining != '0) && can_issue;

   assign m_data    = data0;
   assign m_last    = last0 & m_valid;
   assign level     = level_q;
   assign busy      = busy_q;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q <= '0;
      end else begin
         level_q <= wr_sync - fifo_addr_out;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         remaining <= '0;
         busy_q    <= 1'b0;
         rd_d1     <= 1'b0;
         last_d1   <= 1'b0;
      end else begin
         rd_d1   <= fifo_read;
         last_d1 <= fifo_read && (remaining == ADDR_W'(1));
         case (state)
            ST_IDLE: begin
               if (enable && (level_q >= BURST_CNT)) begin
                  state     <= ST_BURST;
                  remaining <= BURST_CNT;
                  busy_q    <= 1'b1;
               end
            end
            ST_BURST: begin
               if (fifo_read) begin
                  remaining <= remaining - ADDR_W'(1);
                  if (remaining == ADDR_W'(1)) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if ((cnt == 2'd0) && !rd_d1) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Slot 0 is always the head, so m_data comes straight from a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= 2'd0;
         data0 <= '0;
         data1 <= '0;
         last0 <= 1'b0;
         last1 <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) begin
                  data0 <= fifo_data;
                  last0 <= last_d1;
               end else begin
                  data1 <= fifo_data;
                  last1 <= last_d1;
               end
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               data0 <= data1;
               last0 <= last1;
               cnt   <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  data0 <= fifo_data;
                  last0 <= last_d1;
               end else begin
                  data0 <= data1;
                  last0 <= last1;
                  data1 <= fifo_data;
                  last1 <= last_d1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
